// File: rtl/playlist_controller_if.sv
// Playlist controller bus: user buttons, song reader/beat feedback and player-facing outputs.
interface playlist_controller_if #(
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned ELAPSED_W = 16
);
    localparam int unsigned SONG_W = $clog2(NUM_SONGS);

    logic                 play_pause;
    logic                 next;
    logic                 prev;
    logic [1:0]           mode;
    logic                 song_done;
    logic                 beat;
    logic                 play;
    logic [SONG_W-1:0]    song;
    logic                 reset_play;
    logic [ELAPSED_W-1:0] elapsed;

    // Stimulus side: buttons, mode and player feedback out, controller state in
    modport master (
        output play_pause, next, prev, mode, song_done, beat,
        input  play, song, reset_play, elapsed
    );

    // Controller side
    modport slave (
        input  play_pause, next, prev, mode, song_done, beat,
        output play, song, reset_play, elapsed
    );
endinterface

// File: rtl/playlist_controller.sv
// Playlist controller: selects the current song, handles play/pause, next,
// prev (restart or step back) and end-of-song in four play modes, and counts
// beats played in the current song. NUM_SONGS must be in 2..256 because the
// shuffle candidate is drawn from the 8-bit LFSR.
module playlist_controller #(
    parameter int unsigned NUM_SONGS   = 4,
    parameter int unsigned PREV_THRESH = 4,
    parameter int unsigned ELAPSED_W   = 16
) (
    input logic                  clk,
    input logic                  reset,
    playlist_controller_if.slave bus
);
    localparam int unsigned SONG_W  = $clog2(NUM_SONGS);
    localparam int unsigned LFSR_W  = 8;

    localparam logic [SONG_W-1:0]    LAST_SONG  = SONG_W'(NUM_SONGS - 1);
    localparam logic [SONG_W:0]      NUM_WIDE   = (SONG_W + 1)'(NUM_SONGS);
    localparam logic [ELAPSED_W-1:0] THRESH     = ELAPSED_W'(PREV_THRESH);
    localparam logic [LFSR_W-1:0]    LFSR_SEED  = 8'h01;

    localparam logic [1:0] MODE_SEQ        = 2'd0;
    localparam logic [1:0] MODE_LOOP_ALL   = 2'd1;
    localparam logic [1:0] MODE_REPEAT_ONE = 2'd2;
    localparam logic [1:0] MODE_SHUFFLE    = 2'd3;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SONG_W-1:0]    song_q, song_d;
    logic                 play_q, play_d;
    logic                 reset_play_q, reset_play_d;
    logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;

    logic [SONG_W-1:0]    song_inc;
    logic [SONG_W-1:0]    song_dec;
    logic [SONG_W:0]      cand_wide;
    logic [SONG_W-1:0]    cand;
    logic [SONG_W-1:0]    shuffle_pick;
    logic                 load;

    // Free-running Fibonacci LFSR, taps 8,6,5,4
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Neighbour songs and shuffle pick that never repeats the current song
    always_comb begin
        song_inc  = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
        song_dec  = song_q - SONG_W'(1);
        cand_wide = {1'b0, lfsr_q[SONG_W-1:0]};
        if (cand_wide >= NUM_WIDE) begin
            cand_wide = cand_wide - NUM_WIDE;
        end
        cand         = cand_wide[SONG_W-1:0];
        shuffle_pick = (cand == song_q) ? song_inc : cand;
    end

    // Next-state: event arbitration (next > prev > song_done), play toggle, beat count
    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        play_d    = play_q;
        elapsed_d = elapsed_q;
        load      = 1'b0;

        if (bus.play_pause) begin
            play_d = ~play_q;
        end

        case (state_q)
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.next) begin
                    load   = 1'b1;
                    song_d = (bus.mode == MODE_SHUFFLE) ? shuffle_pick : song_inc;
                end else if (bus.prev) begin
                    load = 1'b1;
                    // No shuffle history is kept, so prev is always sequential
                    if (elapsed_q >= THRESH) begin
                        song_d = song_q;
                    end else if (song_q != '0) begin
                        song_d = song_dec;
                    end else if (bus.mode == MODE_SEQ) begin
                        song_d = '0;
                    end else begin
                        song_d = LAST_SONG;
                    end
                end else if (bus.song_done) begin
                    load = 1'b1;
                    case (bus.mode)
                        MODE_SEQ: begin
                            if (song_q == LAST_SONG) begin
                                song_d = '0;
                                play_d = 1'b0;
                            end else begin
                                song_d = song_inc;
                            end
                        end
                        MODE_LOOP_ALL:   song_d = song_inc;
                        MODE_REPEAT_ONE: song_d = song_q;
                        MODE_SHUFFLE:    song_d = shuffle_pick;
                        default:         song_d = song_q;
                    endcase
                end

                if (load) begin
                    state_d   = ST_LOAD;
                    elapsed_d = '0;
                end else if (bus.beat && play_q && (elapsed_q != '1)) begin
                    elapsed_d = elapsed_q + ELAPSED_W'(1);
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        reset_play_d = (state_d == ST_LOAD);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            song_q       <= '0;
            play_q       <= 1'b0;
            reset_play_q <= 1'b1;
            elapsed_q    <= '0;
            lfsr_q       <= LFSR_SEED;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            play_q       <= play_d;
            reset_play_q <= reset_play_d;
            elapsed_q    <= elapsed_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign bus.play       = play_q;
    assign bus.song       = song_q;
    assign bus.reset_play = reset_play_q;
    assign bus.elapsed    = elapsed_q;

endmodule

// File: tb/tb_playlist_controller.sv
// Bench for playlist_controller: directed vector table on a 4-song instance,
// plus shuffle and saturation sequences on 5-song and 3-song instances.
module tb_playlist_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    playlist_controller_if #(.NUM_SONGS(4), .ELAPSED_W(16)) if4 ();
    playlist_controller_if #(.NUM_SONGS(5), .ELAPSED_W(16)) if5 ();
    playlist_controller_if #(.NUM_SONGS(3), .ELAPSED_W(3))  if3 ();

    playlist_controller #(.NUM_SONGS(4), .PREV_THRESH(4), .ELAPSED_W(16)) dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave));
    playlist_controller #(.NUM_SONGS(5), .PREV_THRESH(4), .ELAPSED_W(16)) dut5 (
        .clk(clk), .reset(reset), .bus(if5.slave));
    playlist_controller #(.NUM_SONGS(3), .PREV_THRESH(4), .ELAPSED_W(3)) dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave));

    typedef struct {
        logic       pp;
        logic       nx;
        logic       pv;
        logic [1:0] md;
        logic       sd;
        logic       bt;
        logic       e_play;
        int         e_song;
        logic       e_rp;
        int         e_el;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic pp, input logic nx, input logic pv,
                                input logic [1:0] md, input logic sd, input logic bt,
                                input logic e_play, input int e_song,
                                input logic e_rp, input int e_el);
        vec_t v;
        v.pp = pp; v.nx = nx; v.pv = pv; v.md = md; v.sd = sd; v.bt = bt;
        v.e_play = e_play; v.e_song = e_song; v.e_rp = e_rp; v.e_el = e_el;
        vecs.push_back(v);
    endfunction

    task automatic check4(input string tag, input logic e_play, input int e_song,
                          input logic e_rp, input int e_el);
        check({tag, " play"},       32'(if4.play),       32'(e_play));
        check({tag, " song"},       32'(if4.song),       32'(e_song));
        check({tag, " reset_play"}, 32'(if4.reset_play), 32'(e_rp));
        check({tag, " elapsed"},    32'(if4.elapsed),    32'(e_el));
    endtask

    task automatic idle_all();
        if4.play_pause = 1'b0; if4.next = 1'b0; if4.prev = 1'b0;
        if4.song_done  = 1'b0; if4.beat = 1'b0; if4.mode = 2'd0;
        if5.play_pause = 1'b0; if5.next = 1'b0; if5.prev = 1'b0;
        if5.song_done  = 1'b0; if5.beat = 1'b0; if5.mode = 2'd3;
        if3.play_pause = 1'b0; if3.next = 1'b0; if3.prev = 1'b0;
        if3.song_done  = 1'b0; if3.beat = 1'b0; if3.mode = 2'd3;
    endtask

    initial begin
        int prev_song;
        logic [2:0] seen;

        // pp nx pv md sd bt | play song rp elapsed
        add(0,0,0,0,0,0, 0,0,0,0);          // idle after load
        add(1,0,0,0,0,0, 1,0,0,0);          // start playing
        for (int i = 1; i <= 5; i++) add(0,0,0,0,0,1, 1,0,0,i);
        add(1,0,0,0,0,0, 0,0,0,5);          // pause
        add(0,0,0,0,0,1, 0,0,0,5);          // beats ignored while paused
        add(0,0,0,0,0,1, 0,0,0,5);
        add(1,0,0,0,0,0, 1,0,0,5);          // resume
        add(0,1,0,0,0,0, 1,1,1,0);          // next -> 1
        add(0,0,0,0,0,0, 1,1,0,0);
        add(0,1,0,0,0,0, 1,2,1,0);
        add(0,0,0,0,0,0, 1,2,0,0);
        add(0,1,0,0,0,0, 1,3,1,0);
        add(0,0,0,0,0,0, 1,3,0,0);
        add(0,0,0,0,1,0, 0,0,1,0);          // SEQ done at last song: stop at 0
        add(0,0,0,0,0,0, 0,0,0,0);
        add(1,0,0,1,0,0, 1,0,0,0);
        add(0,1,0,1,0,0, 1,1,1,0);
        add(0,0,0,1,0,0, 1,1,0,0);
        add(0,1,0,1,0,0, 1,2,1,0);
        add(0,0,0,1,0,0, 1,2,0,0);
        add(0,1,0,1,0,0, 1,3,1,0);
        add(0,0,0,1,0,0, 1,3,0,0);
        add(0,0,0,1,1,0, 1,0,1,0);          // LOOP_ALL done at last: wrap, keep playing
        add(0,0,0,1,0,0, 1,0,0,0);
        add(0,1,0,1,0,0, 1,1,1,0);
        add(0,0,0,1,0,0, 1,1,0,0);
        add(0,1,0,1,0,0, 1,2,1,0);
        add(0,0,0,1,0,0, 1,2,0,0);
        for (int i = 1; i <= 7; i++) add(0,0,0,1,0,1, 1,2,0,i);
        add(0,0,1,1,0,0, 1,2,1,0);          // prev with elapsed 7: restart
        add(0,0,0,1,0,0, 1,2,0,0);
        add(0,0,0,1,0,1, 1,2,0,1);
        add(0,0,0,1,0,1, 1,2,0,2);
        add(0,0,1,1,0,0, 1,1,1,0);          // prev with elapsed 2: step back
        add(0,0,0,1,0,0, 1,1,0,0);
        add(0,0,1,1,0,0, 1,0,1,0);
        add(0,0,0,1,0,0, 1,0,0,0);
        add(0,0,1,1,0,0, 1,3,1,0);          // prev at 0 in LOOP_ALL wraps to 3
        add(0,0,0,1,0,0, 1,3,0,0);
        add(0,1,0,0,0,0, 1,0,1,0);          // next wraps in SEQ
        add(0,0,0,0,0,0, 1,0,0,0);
        add(0,0,1,0,0,0, 1,0,1,0);          // prev at 0 in SEQ restarts 0
        add(0,0,0,0,0,0, 1,0,0,0);
        add(0,1,0,1,0,0, 1,1,1,0);
        add(0,0,0,1,0,0, 1,1,0,0);
        add(0,1,0,1,1,0, 1,2,1,0);          // next beats song_done
        add(0,0,0,1,0,0, 1,2,0,0);
        add(0,1,0,1,0,0, 1,3,1,0);
        add(0,1,0,1,0,0, 1,3,0,0);          // next in LOAD ignored
        add(0,0,0,1,0,0, 1,3,0,0);
        add(0,0,0,2,1,0, 1,3,1,0);          // REPEAT_ONE done: same song
        add(1,0,0,2,0,0, 0,3,0,0);          // play_pause honoured in LOAD
        add(1,0,0,2,0,0, 1,3,0,0);
        add(0,1,1,1,0,0, 1,0,1,0);          // next beats prev
        add(0,0,0,1,0,0, 1,0,0,0);
        add(1,1,0,1,0,0, 0,1,1,0);          // play_pause alongside next
        add(1,0,0,1,0,0, 1,1,0,0);

        reset = 1'b0;
        idle_all();
        repeat (3) @(negedge clk);
        check4("reset", 0, 0, 1, 0);
        reset = 1'b1;
        #1;
        check4("release", 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if4.play_pause = vecs[i].pp;
            if4.next       = vecs[i].nx;
            if4.prev       = vecs[i].pv;
            if4.mode       = vecs[i].md;
            if4.song_done  = vecs[i].sd;
            if4.beat       = vecs[i].bt;
            @(posedge clk);
            #1;
            check4($sformatf("vec%0d", i), vecs[i].e_play, vecs[i].e_song,
                   vecs[i].e_rp, vecs[i].e_el);
        end
        @(negedge clk);
        idle_all();

        // Shuffle at 5 songs: always in range, never the previous song
        prev_song = int'(if5.song);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if5.song_done = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("shuf5 range %0d", i), 32'(if5.song < 3'd5), 32'd1);
            check($sformatf("shuf5 repeat %0d", i), 32'(int'(if5.song) != prev_song), 32'd1);
            check($sformatf("shuf5 reset_play %0d", i), 32'(if5.reset_play), 32'd1);
            prev_song = int'(if5.song);
            @(negedge clk);
            if5.song_done = 1'b0;
            @(posedge clk);
        end

        // Shuffle at 3 songs: every song reached, never a repeat
        seen = 3'b000;
        seen[if3.song] = 1'b1;
        prev_song = int'(if3.song);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if3.song_done = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("shuf3 range %0d", i), 32'(if3.song < 2'd3), 32'd1);
            check($sformatf("shuf3 repeat %0d", i), 32'(int'(if3.song) != prev_song), 32'd1);
            if (if3.song < 2'd3) seen[if3.song] = 1'b1;
            prev_song = int'(if3.song);
            @(negedge clk);
            if3.song_done = 1'b0;
            @(posedge clk);
        end
        check("shuf3 coverage", 32'(seen), 32'd7);

        // Elapsed saturates at all-ones (3 bits)
        @(negedge clk);
        if3.play_pause = 1'b1;
        @(negedge clk);
        if3.play_pause = 1'b0;
        if3.beat       = 1'b1;
        repeat (10) @(negedge clk);
        if3.beat = 1'b0;
        check("sat play", 32'(if3.play), 32'd1);
        check("sat elapsed", 32'(if3.elapsed), 32'd7);

        // Asynchronous reset mid-song takes effect before any clock edge
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check4("async reset", 0, 0, 1, 0);
        check("async reset sat", 32'(if3.elapsed), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check4("rerelease", 0, 0, 1, 0);
        @(posedge clk);
        #1;
        check4("rerelease run", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
